datamemory_arbiter: RTL and testbench
=====================================

Name: datamemory_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port datamemory block (32-bit words, 10-bit word address, write-protect select).
- Shares the memory between requester 0 (CPU load/store stage) and requester 1 (I/O or debug loader) using round-robin arbitration.
- Drives the memory-side signals ramIn, ramAdress and ramWP, waits out the synchronous read latency, and returns read data with a one-cycle ack pulse.

Parameters:
ADDR_W, 10, word address width, equal to datamemory ramAdress width
DATA_W, 32, data width, equal to datamemory ramIn/ramOut width
RD_LAT, 1, clock edges from the address sample edge until ramOut is valid; legal range 1..4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req0  in  1  requester 0 access request
we0  in  1  requester 0 direction: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 word address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  one-cycle completion pulse to requester 0
rdata0  out  DATA_W  requester 0 read data, valid when ack0 = 1
req1, we1, addr1, wdata1, ack1, rdata1  same as above, for requester 1
busy  out  1  high in any state other than IDLE
ramIn  out  DATA_W  write data to datamemory
ramAdress  out  ADDR_W  address to datamemory
ramWP  out  1  to datamemory: 1 = read/protected, 0 = write
ramOut  in  DATA_W  read data from datamemory

Behaviour:
- Reset (reset = 0 at a rising edge):
  - state goes to IDLE and the RR pointer is set so requester 0 wins the first tie.
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0, busy = 0.
- Memory outputs:
  - ramAdress and ramIn are 0 in IDLE.
  - ramWP = 1 in every state and cycle except ACCESS with a latched write.
  - ramWP is forced to 1 combinationally whenever reset = 0, so no write commits during a reset cycle. This also covers reset asserted while in ACCESS.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req0 and req1 are sampled here only.
  - If exactly one is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - On a win, latch owner, we, addr and wdata into internal registers, update the RR pointer to the owner, and go to ACCESS.
  - The requester's fields are don't-care after the latch edge.
- ACCESS (1 cycle):
  - ramAdress = latched addr, ramIn = latched wdata, ramWP = ~latched we.
  - A write commits on this cycle's closing edge, then the FSM goes to RESP.
  - A read loads the wait counter with RD_LAT, then the FSM goes to WAIT.
- WAIT:
  - ramAdress is held, ramWP = 1, and the counter decrements each cycle.
  - On the edge where the counter reaches 1, ramOut is captured into the owner's rdata register, then the FSM goes to RESP.
- RESP (1 cycle): ack of the owner = 1, then the FSM goes to IDLE. The other ack stays 0.
- Latency, with request seen in IDLE at cycle T:
  - write: ack at T+2.
  - read: ack at T+2+RD_LAT.
- Per-requester throughput: one access per 3 cycles for writes, 3+RD_LAT cycles for reads.
- rdataN holds its value until requester N's next read completes. Writes never modify rdataN.
- Handshake:
  - A requester holds reqN high until ackN.
  - A reqN still high in the IDLE cycle after RESP is a new request and is arbitrated normally.
  - With both requesters holding req continuously, grants strictly alternate.
- No address range checking: the full 2^ADDR_W space is passed through.
- RD_LAT outside 1..4 is unsupported; the implementation asserts in simulation.

Test Plan:
1. RD_LAT=1, reset released. req0 write addr=4, wdata=A0000000 → ramWP=0 for exactly one cycle with ramAdress=4, ack0 at T+2. Then req0 read addr=4 → ack0 at T+3 with rdata0=A0000000.
2. Both requesters assert in the same cycle: req0 write addr=5 data=50000000, req1 write addr=6 data=F0000000. Requester 0 is granted first (post-reset tie), ack0 at T+2. Requester 1 is granted in the next IDLE, ack1 at T+5. Readback gives 50000000 and F0000000.
3. Both reqs held high for 6 grants → owner sequence is 0,1,0,1,0,1. ack0 and ack1 never assert together.
4. RD_LAT=2, memory model with 2-edge read latency preloaded with addr 7 = 70000000. req1 read addr=7 → ack1 at T+4, rdata1=70000000; rdata0 is unchanged.
5. Reset driven low during the ACCESS cycle of a write to addr 3 (preloaded 0BB8) → ramWP stays 1 and addr 3 still reads 0BB8. After reset: state IDLE, busy=0, acks 0, rdata0 = rdata1 = 0.
6. Idle with no requests for 20 cycles → ramWP=1, ramAdress=0, busy=0 throughout, and memory contents are unchanged.

Source files
------------

// File: rtl/datamemory_arbiter.sv
// Round-robin arbiter and access sequencer that shares one single-port datamemory
// between the CPU load/store stage (requester 0) and an I/O or debug loader (requester 1).
//
// state  | meaning
// IDLE   | sample req0/req1, grant one requester and latch its access
// ACCESS | drive latched address/data; a write commits on this cycle's closing edge
// WAIT   | read in flight, counting down the memory read latency
// RESP   | one-cycle ack pulse to the owner
module datamemory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [DATA_W-1:0] ramIn,
  output logic [ADDR_W-1:0] ramAdress,
  output logic              ramWP,
  input  logic [DATA_W-1:0] ramOut
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : gBadRdLat
    $error("datamemory_arbiter: RD_LAT=%0d is outside the supported range 1..4", RD_LAT);
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} stateT;

  stateT      state;
  logic       lastOwner;
  logic       owner;
  logic       latWe;
  logic       ramWpReg;
  logic       grant;
  logic [2:0] waitCnt;

  // A tie goes to whoever was not granted last; a lone request simply wins.
  assign grant = (req0 && req1) ? ~lastOwner : req1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      lastOwner <= 1'b1;
      owner     <= 1'b0;
      latWe     <= 1'b0;
      ramWpReg  <= 1'b1;
      waitCnt   <= 3'd0;
      ramAdress <= '0;
      ramIn     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= grant;
            lastOwner <= grant;
            latWe     <= grant ? we1 : we0;
            ramAdress <= grant ? addr1 : addr0;
            ramIn     <= grant ? wdata1 : wdata0;
            ramWpReg  <= grant ? ~we1 : ~we0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ramWpReg <= 1'b1;
          if (latWe) begin
            ack0  <= ~owner;
            ack1  <= owner;
            state <= RESP;
          end else begin
            waitCnt <= 3'(RD_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == 3'd1) begin
            if (owner) rdata1 <= ramOut;
            else       rdata0 <= ramOut;
            ack0  <= ~owner;
            ack1  <= owner;
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        RESP: begin
          ramAdress <= '0;
          ramIn     <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Reset must block a write even mid-ACCESS, so it bypasses the register.
  assign ramWP = ramWpReg | ~reset;

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Bench for datamemory_arbiter: two instances (read latency 1 and 2), each with its
// own behavioural datamemory, checked against vector tables and a transaction-level model.
module tb_datamemory_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 2;
  localparam int NVEC = 8;

  logic clock = 1'b0;
  logic reset;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2][2];
  logic          busy  [2];
  logic          ramWP [2];
  logic [DW-1:0] ramIn [2];
  logic [DW-1:0] ramOut [2];
  logic [AW-1:0] ramAdress [2];

  logic          memClr;
  logic          plEn [2];
  logic [AW-1:0] plAddr;
  logic [DW-1:0] plData;

  logic [DW-1:0] gold [2][1<<AW];
  logic [DW-1:0] expRd [2][2];
  logic          modelLast [2];
  int nChecks = 0;
  int nFail = 0;

  always #5 clock = ~clock;

  datamemory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT0)) dut0 (
    .clock(clock), .reset(reset),
    .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
    .ack0(ack[0][0]), .rdata0(rdata[0][0]),
    .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
    .ack1(ack[0][1]), .rdata1(rdata[0][1]),
    .busy(busy[0]), .ramIn(ramIn[0]), .ramAdress(ramAdress[0]), .ramWP(ramWP[0]),
    .ramOut(ramOut[0]));

  datamemory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1)) dut1 (
    .clock(clock), .reset(reset),
    .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
    .ack0(ack[1][0]), .rdata0(rdata[1][0]),
    .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
    .ack1(ack[1][1]), .rdata1(rdata[1][1]),
    .busy(busy[1]), .ramIn(ramIn[1]), .ramAdress(ramAdress[1]), .ramWP(ramWP[1]),
    .ramOut(ramOut[1]));

  // Behavioural datamemory: write on !ramWP, read data valid LAT edges after the address edge.
  for (genvar g = 0; g < 2; g++) begin : gMem
    localparam int L = (g == 0) ? LAT0 : LAT1;
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] pipe [L];
    always @(posedge clock) begin
      if (memClr) begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      end else begin
        if (plEn[g]) mem[plAddr] <= plData;
        if (!ramWP[g]) mem[ramAdress[g]] <= ramIn[g];
      end
      pipe[0] <= mem[ramAdress[g]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ramOut[g] = pipe[L-1];
  end

  function automatic int latOf(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      modelLast[d] = 1'b1;
      for (int n = 0; n < 2; n++) expRd[d][n] = '0;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 2; n++) req[d][n] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset busy d%0d", d), busy[d], 0);
      chk($sformatf("reset ramWP d%0d", d), ramWP[d], 1);
      chk($sformatf("reset ramAdress d%0d", d), ramAdress[d], 0);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("reset ack%0d d%0d", n, d), ack[d][n], 0);
        chk($sformatf("reset rdata%0d d%0d", n, d), rdata[d][n], 0);
      end
    end
    reset = 1'b1;
    resetModel();
    @(negedge clock);
  endtask

  task automatic preload(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    plAddr = a;
    plData = v;
    plEn[d] = 1'b1;
    @(negedge clock);
    plEn[d] = 1'b0;
    gold[d][a] = v;
  endtask

  // One request from one requester; returns latency (cycles after the request cycle).
  task automatic singleAccess(input int d, input int who, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] v, output int lat, output logic [DW-1:0] rd,
                              output int wpLow, output logic [AW-1:0] wpAddr, output int otherAck);
    lat = -1; rd = '0; wpLow = 0; wpAddr = '0; otherAck = 0;
    req[d][who] = 1'b1; we[d][who] = w; addr[d][who] = a; wdata[d][who] = v;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (!ramWP[d]) begin
        wpLow++;
        wpAddr = ramAdress[d];
      end
      if (ack[d][1-who]) otherAck++;
      if (ack[d][who]) begin
        lat = k;
        rd = rdata[d][who];
        break;
      end
    end
    req[d][who] = 1'b0;
    @(negedge clock);
  endtask

  // Requests from the requesters in mask, all raised in one IDLE cycle; each drops on its ack.
  task automatic burst(input int d, input logic [1:0] mask, input logic w [2],
                       input logic [AW-1:0] a [2], input logic [DW-1:0] v [2], output int ackAt [2]);
    int expAt [2];
    logic [DW-1:0] expRead [2];
    int first, second, last;
    logic wpExp, busyExp;
    logic [AW-1:0] adrExp;
    expAt[0] = -1; expAt[1] = -1; ackAt[0] = -1; ackAt[1] = -1;
    expRead[0] = '0; expRead[1] = '0;
    first = (mask == 2'b11) ? (modelLast[d] ? 0 : 1) : (mask[1] ? 1 : 0);
    second = 1 - first;
    expAt[first] = w[first] ? 2 : 2 + latOf(d);
    if (mask == 2'b11) expAt[second] = expAt[first] + 1 + (w[second] ? 2 : 2 + latOf(d));
    if (w[first]) gold[d][a[first]] = v[first]; else expRead[first] = gold[d][a[first]];
    if (mask == 2'b11) begin
      if (w[second]) gold[d][a[second]] = v[second]; else expRead[second] = gold[d][a[second]];
    end
    modelLast[d] = (mask == 2'b11) ? second[0] : first[0];
    last = (mask == 2'b11) ? expAt[second] : expAt[first];
    for (int n = 0; n < 2; n++) begin
      req[d][n] = mask[n]; we[d][n] = w[n]; addr[d][n] = a[n]; wdata[d][n] = v[n];
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      wpExp = 1'b1;
      adrExp = '0;
      for (int n = 0; n < 2; n++)
        if (mask[n] && w[n] && k == expAt[n] - 1) begin
          wpExp = 1'b0;
          adrExp = a[n];
        end
      busyExp = (k <= expAt[first]) || (mask == 2'b11 && k >= expAt[first] + 2);
      chk($sformatf("burst d%0d k%0d ramWP", d, k), ramWP[d], wpExp);
      if (!wpExp) chk($sformatf("burst d%0d k%0d ramAdress", d, k), ramAdress[d], adrExp);
      chk($sformatf("burst d%0d k%0d busy", d, k), busy[d], busyExp);
      for (int n = 0; n < 2; n++) begin
        if (k == expAt[n] && !w[n]) expRd[d][n] = expRead[n];
        chk($sformatf("burst d%0d k%0d ack%0d", d, k, n), ack[d][n], k == expAt[n]);
        chk($sformatf("burst d%0d k%0d rdata%0d", d, k, n), rdata[d][n], expRd[d][n]);
        if (ack[d][n]) begin
          ackAt[n] = k;
          req[d][n] = 1'b0;
        end
      end
    end
    req[d][0] = 1'b0;
    req[d][1] = 1'b0;
    @(negedge clock);
  endtask

  typedef struct {
    int d; int who; logic w; logic [AW-1:0] a; logic [DW-1:0] v; int expLat; logic [DW-1:0] expRdata;
  } vecT;
  vecT vecs [NVEC];

  int lat, wpLow, oAck, first, nGrant, both, diffs;
  logic [DW-1:0] rd;
  logic [AW-1:0] wpAddr;
  logic rw [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rv [2];
  int at [2];

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 1'b1, 10'd4,     32'hA000_0000, 2, 32'h0};
    vecs[1] = '{0, 0, 1'b0, 10'd4,     32'h0,         3, 32'hA000_0000};
    vecs[2] = '{0, 1, 1'b1, 10'h3FF,   32'h1234_5678, 2, 32'h0};
    vecs[3] = '{0, 1, 1'b0, 10'h3FF,   32'h0,         3, 32'h1234_5678};
    vecs[4] = '{1, 1, 1'b0, 10'd7,     32'h0,         4, 32'h7000_0000};
    vecs[5] = '{1, 0, 1'b1, 10'd0,     32'hCAFE_F00D, 2, 32'h0};
    vecs[6] = '{1, 0, 1'b0, 10'd0,     32'h0,         4, 32'hCAFE_F00D};
    vecs[7] = '{0, 0, 1'b0, 10'h3FF,   32'h0,         3, 32'h1234_5678};

    reset = 1'b0;
    memClr = 1'b1;
    plEn[0] = 1'b0; plEn[1] = 1'b0; plAddr = '0; plData = '0;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        req[d][n] = 1'b0; we[d][n] = 1'b0; addr[d][n] = '0; wdata[d][n] = '0;
      end
      for (int i = 0; i < (1 << AW); i++) gold[d][i] = '0;
    end
    resetModel();
    @(negedge clock);
    @(negedge clock);
    memClr = 1'b0;
    preload(1, 10'd7, 32'h7000_0000);
    doReset();

    // Single accesses, including the read-latency-2 instance and the top address.
    for (int i = 0; i < NVEC; i++) begin
      singleAccess(vecs[i].d, vecs[i].who, vecs[i].w, vecs[i].a, vecs[i].v, lat, rd, wpLow, wpAddr, oAck);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      chk($sformatf("vec%0d ramWP low cycles", i), wpLow, vecs[i].w ? 1 : 0);
      if (vecs[i].w) begin
        chk($sformatf("vec%0d write ramAdress", i), wpAddr, vecs[i].a);
        gold[vecs[i].d][vecs[i].a] = vecs[i].v;
      end else begin
        chk($sformatf("vec%0d rdata", i), rd, vecs[i].expRdata);
        expRd[vecs[i].d][vecs[i].who] = vecs[i].expRdata;
      end
      chk($sformatf("vec%0d other ack", i), oAck, 0);
      chk($sformatf("vec%0d own rdata held", i), rdata[vecs[i].d][vecs[i].who], expRd[vecs[i].d][vecs[i].who]);
      chk($sformatf("vec%0d other rdata held", i), rdata[vecs[i].d][1-vecs[i].who], expRd[vecs[i].d][1-vecs[i].who]);
      modelLast[vecs[i].d] = vecs[i].who[0];
    end

    // Simultaneous writes right after reset: requester 0 wins the first tie.
    doReset();
    rw[0] = 1'b1; rw[1] = 1'b1; ra[0] = 10'd5; ra[1] = 10'd6;
    rv[0] = 32'h5000_0000; rv[1] = 32'hF000_0000;
    burst(0, 2'b11, rw, ra, rv, at);
    chk("tie ack0 cycle", at[0], 2);
    chk("tie ack1 cycle", at[1], 5);
    singleAccess(0, 0, 1'b0, 10'd5, '0, lat, rd, wpLow, wpAddr, oAck);
    chk("tie readback 5", rd, 32'h5000_0000);
    expRd[0][0] = 32'h5000_0000; modelLast[0] = 1'b0;
    singleAccess(0, 1, 1'b0, 10'd6, '0, lat, rd, wpLow, wpAddr, oAck);
    chk("tie readback 6", rd, 32'hF000_0000);
    expRd[0][1] = 32'hF000_0000; modelLast[0] = 1'b1;

    // Both requests held continuously: grants must alternate.
    first = modelLast[0] ? 0 : 1;
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 10'd20; wdata[0][0] = 32'h1414_1414;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 10'd21; wdata[0][1] = 32'h1515_1515;
    nGrant = 0;
    both = 0;
    for (int k = 1; k <= 40 && nGrant < 6; k++) begin
      @(negedge clock);
      if (ack[0][0] && ack[0][1]) both++;
      if (ack[0][0] || ack[0][1]) begin
        chk($sformatf("alternate grant %0d owner", nGrant), ack[0][1], (nGrant % 2 == 0) ? first : 1 - first);
        nGrant++;
      end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("alternate grant count", nGrant, 6);
    chk("alternate simultaneous acks", both, 0);
    gold[0][20] = 32'h1414_1414;
    gold[0][21] = 32'h1515_1515;
    modelLast[0] = (first == 0);
    @(negedge clock);

    // Reset during the ACCESS cycle of a write must block the write.
    preload(0, 10'd3, 32'h0000_0BB8);
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 10'd3; wdata[0][0] = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("reset-in-access ramWP before reset", ramWP[0], 0);
    reset = 1'b0;
    #1;
    chk("reset-in-access ramWP forced", ramWP[0], 1);
    req[0][0] = 1'b0;
    @(negedge clock);
    chk("reset-in-access mem[3]", gMem[0].mem[3], 32'h0000_0BB8);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset-in-access busy d%0d", d), busy[d], 0);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("reset-in-access ack%0d d%0d", n, d), ack[d][n], 0);
        chk($sformatf("reset-in-access rdata%0d d%0d", n, d), rdata[d][n], 0);
      end
    end
    reset = 1'b1;
    resetModel();
    @(negedge clock);
    singleAccess(0, 0, 1'b0, 10'd3, '0, lat, rd, wpLow, wpAddr, oAck);
    chk("reset-in-access readback", rd, 32'h0000_0BB8);
    expRd[0][0] = 32'h0000_0BB8; modelLast[0] = 1'b0;

    // Idle with no requests.
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("idle d%0d k%0d ramWP", d, k), ramWP[d], 1);
        chk($sformatf("idle d%0d k%0d ramAdress", d, k), ramAdress[d], 0);
        chk($sformatf("idle d%0d k%0d busy", d, k), busy[d], 0);
      end
    end
    diffs = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (gMem[0].mem[i] !== gold[0][i]) diffs++;
      if (gMem[1].mem[i] !== gold[1][i]) diffs++;
    end
    chk("idle memory contents", diffs, 0);

    // Random traffic against the transaction-level model.
    for (int it = 0; it < 150; it++) begin
      for (int n = 0; n < 2; n++) begin
        rw[n] = 1'($urandom_range(0, 1));
        ra[n] = AW'($urandom_range(0, 15));
        rv[n] = $urandom;
      end
      burst($urandom_range(0, 1), 2'($urandom_range(1, 3)), rw, ra, rv, at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
